dnn_dot_accel: RTL and testbench



---
 rtl/dnn_pkg.sv | 24 ++
 rtl/q16_mul.sv | 26 ++
 rtl/dnn_dot_accel.sv | 186 ++++++++++++++++++
 tb/tb_dnn_dot_accel.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// dnn_pkg: shared definitions for the dot-product accelerator.
//   - register map word offsets seen by the CPU
//   - FSM state encoding
//   - Q16.16 fixed-point type and default fractional width
package dnn_pkg;

    localparam int FRAC_BITS_DEF = 16;

    localparam logic [3:0] REG_CTRL   = 4'd0;  // write: start, read: result
    localparam logic [3:0] REG_BIAS   = 4'd1;
    localparam logic [3:0] REG_WBASE  = 4'd2;
    localparam logic [3:0] REG_ABASE  = 4'd3;
    localparam logic [3:0] REG_OADDR  = 4'd4;
    localparam logic [3:0] REG_LEN    = 4'd5;
    localparam logic [3:0] REG_RELU   = 4'd6;
    localparam logic [3:0] REG_STATUS = 4'd7;

    typedef enum logic [2:0] {
        IDLE, RD_W, WT_W, RD_A, WT_A, MAC, FIN, WR
    } state_e;

    typedef logic signed [31:0] q16_t;

endpackage

// File: rtl/q16_mul.sv
// q16_mul: combinational signed 32x32 fixed-point multiply.
//   a, b : Q16.16 operands
//   p    : full 64-bit product re-aligned to Q16.16 (bits FRAC_BITS+31:FRAC_BITS),
//          upper bits discarded (two's-complement wrap)
module q16_mul
    import dnn_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  q16_t a,
    input  q16_t b,
    output q16_t p
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] full;

    always_comb begin
        a_ext = {{32{a[31]}}, a};
        b_ext = {{32{b[31]}}, b};
        full  = a_ext * b_ext;
        p     = q16_t'(full >>> FRAC_BITS);
    end

endmodule

// File: rtl/dnn_dot_accel.sv
// dnn_dot_accel: Avalon-MM dot-product engine.
//   clk, rst            : clock, synchronous active-high reset
//   slave_*             : CPU register port (zero read latency, stalls while busy)
//   master_*            : SDRAM initiator, one outstanding read, single write of result
// Software programs bias/bases/length/relu, writes offset 0 to start, and reads the
// Q16.16 result back from offset 0 once status (offset 7) clears.
module dnn_dot_accel
    import dnn_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int MAX_LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest
);

    state_e                state_q, state_d;
    q16_t                  acc_q, acc_d, res_q, res_d, bias_q, bias_d;
    q16_t                  w_q, w_d, a_q, a_d, prod;
    logic [31:0]           wbase_q, wbase_d, abase_q, abase_d, oaddr_q, oaddr_d;
    logic [31:0]           wptr_q, wptr_d, aptr_q, aptr_d;
    logic [MAX_LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic [MAX_LEN_W:0]    idx_nxt;
    logic                  relu_q, relu_d;
    logic                  busy, wr_en;

    q16_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (.a(w_q), .b(a_q), .p(prod));

    assign busy = (state_q != IDLE);

    // Config/result offsets stall while busy so software never sees a half-done
    // result or changes operands mid-run; status and unmapped offsets never stall.
    assign slave_waitrequest = busy && (slave_read || slave_write) && (slave_address < REG_STATUS);
    assign wr_en             = slave_write && !slave_waitrequest;

    always_comb begin
        slave_readdata = '0;
        if (slave_read && !slave_waitrequest) begin
            case (slave_address)
                REG_CTRL:   slave_readdata = res_q;
                REG_BIAS:   slave_readdata = bias_q;
                REG_WBASE:  slave_readdata = wbase_q;
                REG_ABASE:  slave_readdata = abase_q;
                REG_OADDR:  slave_readdata = oaddr_q;
                REG_LEN:    slave_readdata = 32'(len_q);
                REG_RELU:   slave_readdata = {31'd0, relu_q};
                REG_STATUS: slave_readdata = {31'd0, busy};
                default:    slave_readdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        res_d            = res_q;
        bias_d           = bias_q;
        w_d              = w_q;
        a_d              = a_q;
        wbase_d          = wbase_q;
        abase_d          = abase_q;
        oaddr_d          = oaddr_q;
        wptr_d           = wptr_q;
        aptr_d           = aptr_q;
        len_d            = len_q;
        idx_d            = idx_q;
        relu_d           = relu_q;
        idx_nxt          = {1'b0, idx_q} + 1'b1;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;

        if (wr_en) begin
            case (slave_address)
                REG_BIAS:  bias_d  = slave_writedata;
                REG_WBASE: wbase_d = slave_writedata;
                REG_ABASE: abase_d = slave_writedata;
                REG_OADDR: oaddr_d = slave_writedata;
                REG_LEN:   len_d   = slave_writedata[MAX_LEN_W-1:0];
                REG_RELU:  relu_d  = slave_writedata[0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (wr_en && slave_address == REG_CTRL) begin
                    acc_d   = bias_q;
                    idx_d   = '0;
                    wptr_d  = wbase_q;
                    aptr_d  = abase_q;
                    state_d = (len_q == '0) ? FIN : RD_W;
                end
            end
            RD_W: begin
                master_read    = 1'b1;
                master_address = wptr_q;
                if (!master_waitrequest) state_d = WT_W;
            end
            WT_W: begin
                if (master_readdatavalid) begin
                    w_d     = master_readdata;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                master_read    = 1'b1;
                master_address = aptr_q;
                if (!master_waitrequest) state_d = WT_A;
            end
            WT_A: begin
                if (master_readdatavalid) begin
                    a_d     = master_readdata;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_q + prod;
                wptr_d  = wptr_q + 32'd4;
                aptr_d  = aptr_q + 32'd4;
                idx_d   = idx_nxt[MAX_LEN_W-1:0];
                state_d = (idx_nxt < {1'b0, len_q}) ? RD_W : FIN;
            end
            FIN: begin
                res_d   = (relu_q && acc_q[31]) ? '0 : acc_q;
                state_d = WR;
            end
            WR: begin
                master_write     = 1'b1;
                master_address   = oaddr_q;
                master_writedata = res_q;
                if (!master_waitrequest) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            bias_q  <= '0;
            w_q     <= '0;
            a_q     <= '0;
            wbase_q <= '0;
            abase_q <= '0;
            oaddr_q <= '0;
            wptr_q  <= '0;
            aptr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            bias_q  <= bias_d;
            w_q     <= w_d;
            a_q     <= a_d;
            wbase_q <= wbase_d;
            abase_q <= abase_d;
            oaddr_q <= oaddr_d;
            wptr_q  <= wptr_d;
            aptr_q  <= aptr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            relu_q  <= relu_d;
        end
    end

endmodule

// File: tb/tb_dnn_dot_accel.sv
module tb_dnn_dot_accel;

    localparam logic [31:0] WB = 32'h0000_1000;
    localparam logic [31:0] AB = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0, slave_write = 1'b0;
    logic [31:0] slave_writedata = '0, slave_readdata;
    logic        slave_waitrequest;
    logic [31:0] master_address, master_readdata, master_writedata;
    logic        master_read, master_write, master_readdatavalid;
    logic        master_waitrequest = 1'b0;

    // SDRAM model state
    logic [31:0] mem [0:4095];
    logic        mdl_rdv = 1'b0, inj_rdv = 1'b0;
    logic [31:0] mdl_rdata = '0, inj_rdata = '0;
    bit          bp = 0, in_req = 0, pend = 0, hold_vld = 0;
    int          stall_left = 0, lat_left = 0;
    int          n_reads = 0, n_writes = 0, n_unstable = 0, n_rw_both = 0;
    logic [31:0] raddr = '0, hold_addr = '0, hold_wd = '0;
    logic        hold_rd = 1'b0, hold_wr = 1'b0;

    logic [31:0] wv [16];
    logic [31:0] av [16];

    int vectors = 0, errs = 0;

    assign master_readdatavalid = mdl_rdv | inj_rdv;
    assign master_readdata      = inj_rdv ? inj_rdata : mdl_rdata;

    always #5 clk = ~clk;

    dnn_dot_accel dut (
        .clk(clk), .rst(rst),
        .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
        .slave_waitrequest(slave_waitrequest),
        .master_address(master_address), .master_read(master_read),
        .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest)
    );

    // Acceptance side of the memory: commits writes, queues reads, watches stability.
    always @(posedge clk) begin
        if (rst) begin
            in_req = 0; pend = 0; hold_vld = 0;
        end else begin
            if (master_read && master_write) n_rw_both++;
            if (hold_vld && (master_address !== hold_addr || master_read !== hold_rd ||
                             master_write !== hold_wr || master_writedata !== hold_wd))
                n_unstable++;
            hold_vld = 0;
            if ((master_read || master_write) && master_waitrequest) begin
                hold_vld = 1; hold_addr = master_address; hold_rd = master_read;
                hold_wr = master_write; hold_wd = master_writedata;
            end else if (master_read || master_write) begin
                in_req = 0;
                if (master_write) begin
                    mem[master_address[13:2]] = master_writedata;
                    n_writes++;
                end else begin
                    n_reads++;
                    pend = 1;
                    raddr = master_address;
                    lat_left = bp ? int'($urandom_range(2, 5)) : 1;
                end
            end
        end
    end

    // Response side: waitrequest stalls and delayed readdatavalid.
    always @(negedge clk) begin
        if (rst) begin
            mdl_rdv = 0; master_waitrequest = 0; stall_left = 0;
        end else begin
            mdl_rdv = 0;
            if (pend) begin
                lat_left--;
                if (lat_left == 0) begin
                    pend = 0; mdl_rdv = 1; mdl_rdata = mem[raddr[13:2]];
                end
            end
            if (master_read || master_write) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = bp ? int'($urandom_range(1, 3)) : 0;
                end
                if (stall_left > 0) begin
                    master_waitrequest = 1; stall_left--;
                end else master_waitrequest = 0;
            end else master_waitrequest = 0;
        end
    end

    // Reference: Q16.16 dot product with 32-bit wrap, bias, optional ReLU.
    function automatic logic [31:0] ref_dot(int n, logic [31:0] bias, bit relu);
        logic [31:0] r;
        longint p;
        r = bias;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(wv[i])) * longint'($signed(av[i]));
            r = r + 32'(p >>> 16);
        end
        if (relu && r[31]) r = '0;
        return r;
    endfunction

    task automatic cpu_wr(input logic [3:0] ad, input logic [31:0] d, output int st);
        @(negedge clk);
        slave_address = ad; slave_writedata = d; slave_write = 1'b1;
        #1; st = 0;
        while (slave_waitrequest && st < 20000) begin @(negedge clk); #1; st++; end
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [3:0] ad, output logic [31:0] d, output int st);
        @(negedge clk);
        slave_address = ad; slave_read = 1'b1;
        #1; st = 0;
        while (slave_waitrequest && st < 20000) begin @(negedge clk); #1; st++; end
        d = slave_readdata;
        @(posedge clk); #1;
        slave_read = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        logic [31:0] s;
        int st;
        ok = 0;
        for (int n = 0; n < 5000; n++) begin
            cpu_rd(4'd7, s, st);
            if (s[0] == 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic program_job(int n, logic [31:0] bias, bit relu, logic [31:0] oaddr);
        int st;
        for (int i = 0; i < n; i++) begin
            mem[WB[13:2] + 12'(i)] = wv[i];
            mem[AB[13:2] + 12'(i)] = av[i];
        end
        mem[oaddr[13:2]] = 32'hDEAD_BEEF;
        cpu_wr(4'd1, bias, st);
        cpu_wr(4'd2, WB, st);
        cpu_wr(4'd3, AB, st);
        cpu_wr(4'd4, oaddr, st);
        cpu_wr(4'd5, 32'(n), st);
        cpu_wr(4'd6, {31'd0, relu}, st);
        n_reads = 0; n_writes = 0;
    endtask

    task automatic run_job(int n, logic [31:0] bias, bit relu, logic [31:0] oaddr,
                           output logic [31:0] rm, output logic [31:0] rr, output bit ok);
        int st;
        program_job(n, bias, relu, oaddr);
        cpu_wr(4'd0, 32'd1, st);
        wait_done(ok);
        rm = mem[oaddr[13:2]];
        cpu_rd(4'd0, rr, st);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int st;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({master_read, master_write, slave_waitrequest} !== 3'b000 || master_address !== '0) begin
            errs++; $display("FAIL reset_master got rd=%b wr=%b wait=%b addr=%h want 0", master_read, master_write, slave_waitrequest, master_address);
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            cpu_rd(4'(a), d, st);
            vectors++;
            if (d !== 32'd0 || st != 0) begin
                errs++; $display("FAIL reset_reg%0d got %h stalls=%0d want 0", a, d, st);
            end
        end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        int st;
        cpu_wr(4'd1, 32'hCAFE_F00D, st);
        cpu_wr(4'd5, 32'hABCD_1234, st);
        cpu_wr(4'd6, 32'hFFFF_FFFE, st);
        cpu_wr(4'd9, 32'h5555_5555, st);
        cpu_rd(4'd1, d, st); vectors++;
        if (d !== 32'hCAFE_F00D) begin errs++; $display("FAIL reg_bias got %h want cafef00d", d); end
        cpu_rd(4'd5, d, st); vectors++;
        if (d !== 32'h0000_1234) begin errs++; $display("FAIL reg_len got %h want 00001234", d); end
        cpu_rd(4'd6, d, st); vectors++;
        if (d !== 32'h0) begin errs++; $display("FAIL reg_relu got %h want 0", d); end
        cpu_rd(4'd9, d, st); vectors++;
        if (d !== 32'h0) begin errs++; $display("FAIL reg_unmapped got %h want 0", d); end
    endtask

    task automatic test_basic;
        logic [31:0] rm, rr;
        bit ok;
        bp = 0;
        for (int i = 0; i < 3; i++) begin wv[i] = 32'h0001_0000; av[i] = 32'h0002_0000; end
        run_job(3, 32'h0000_8000, 0, 32'h100, rm, rr, ok);
        vectors++; if (!ok) begin errs++; $display("FAIL basic_done got timeout want idle"); end
        vectors++; if (rm !== 32'h0006_8000) begin errs++; $display("FAIL basic_mem got %h want 00068000", rm); end
        vectors++; if (rr !== 32'h0006_8000) begin errs++; $display("FAIL basic_reg got %h want 00068000", rr); end
        vectors++;
        if (n_reads != 6 || n_writes != 1) begin
            errs++; $display("FAIL basic_counts got reads=%0d writes=%0d want 6/1", n_reads, n_writes);
        end
    endtask

    task automatic test_relu;
        logic [31:0] rm, rr;
        bit ok;
        bp = 0;
        for (int i = 0; i < 2; i++) begin wv[i] = 32'hFFFF_0000; av[i] = 32'h0001_0000; end
        run_job(2, 32'h0, 1, 32'h104, rm, rr, ok);
        vectors++;
        if (!ok || rm !== 32'h0 || rr !== 32'h0) begin
            errs++; $display("FAIL relu_on got mem=%h reg=%h ok=%0d want 0", rm, rr, ok);
        end
        run_job(2, 32'h0, 0, 32'h104, rm, rr, ok);
        vectors++;
        if (!ok || rm !== 32'hFFFE_0000 || rr !== 32'hFFFE_0000) begin
            errs++; $display("FAIL relu_off got mem=%h reg=%h ok=%0d want fffe0000", rm, rr, ok);
        end
    endtask

    task automatic test_len0;
        logic [31:0] rm, rr;
        bit ok;
        bp = 0;
        run_job(0, 32'h1234_5678, 0, 32'h108, rm, rr, ok);
        vectors++;
        if (!ok || rm !== 32'h1234_5678 || rr !== 32'h1234_5678) begin
            errs++; $display("FAIL len0_result got mem=%h reg=%h ok=%0d want 12345678", rm, rr, ok);
        end
        vectors++;
        if (n_reads != 0 || n_writes != 1) begin
            errs++; $display("FAIL len0_counts got reads=%0d writes=%0d want 0/1", n_reads, n_writes);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] m0, r0, m1, r1, exp_v, bias;
        bit ok0, ok1, relu;
        int n;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            bias = $urandom;
            relu = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                wv[i] = (k < 3) ? 32'($signed(20'($urandom))) : $urandom;
                av[i] = (k < 3) ? 32'($signed(20'($urandom))) : $urandom;
            end
            exp_v = ref_dot(n, bias, relu);
            bp = 0;
            run_job(n, bias, relu, 32'h200, m0, r0, ok0);
            vectors++;
            if (!ok0 || m0 !== exp_v || r0 !== exp_v || n_reads != 2 * n) begin
                errs++; $display("FAIL rand_nostall[%0d] got mem=%h reg=%h reads=%0d want %h reads=%0d", k, m0, r0, n_reads, exp_v, 2 * n);
            end
            bp = 1; n_unstable = 0; n_rw_both = 0;
            run_job(n, bias, relu, 32'h200, m1, r1, ok1);
            vectors++;
            if (!ok1 || m1 !== m0 || r1 !== exp_v) begin
                errs++; $display("FAIL rand_stall[%0d] got mem=%h reg=%h want %h", k, m1, r1, exp_v);
            end
            vectors++;
            if (n_unstable != 0 || n_rw_both != 0) begin
                errs++; $display("FAIL rand_stable[%0d] got unstable=%0d rw_both=%0d want 0", k, n_unstable, n_rw_both);
            end
        end
        bp = 0;
    endtask

    task automatic test_slave_stall;
        logic [31:0] d, exp_v;
        int st;
        bit ok;
        bp = 1;
        for (int i = 0; i < 4; i++) begin wv[i] = $urandom_range(0, 32'h3_FFFF); av[i] = $urandom_range(0, 32'h3_FFFF); end
        exp_v = ref_dot(4, 32'h0000_0100, 0);
        program_job(4, 32'h0000_0100, 0, 32'h10C);
        cpu_wr(4'd0, 32'd1, st);
        cpu_rd(4'd0, d, st);
        vectors++;
        if (st == 0 || d !== exp_v) begin
            errs++; $display("FAIL stall_res_read got %h stalls=%0d want %h stalls>0", d, st, exp_v);
        end
        cpu_rd(4'd7, d, st);
        vectors++;
        if (d !== 32'd0) begin errs++; $display("FAIL stall_idle_after got %h want 0", d); end
        cpu_wr(4'd0, 32'd1, st);
        cpu_rd(4'd7, d, st);
        vectors++;
        if (d !== 32'd1 || st != 0) begin
            errs++; $display("FAIL stall_status got %h stalls=%0d want 1/0", d, st);
        end
        wait_done(ok);
        vectors++; if (!ok) begin errs++; $display("FAIL stall_done got timeout want idle"); end
        bp = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d, rm, rr, exp_v;
        int st, cyc;
        bit ok;
        bp = 1;
        for (int i = 0; i < 2; i++) begin wv[i] = 32'h0003_0000; av[i] = 32'h0000_8000; end
        program_job(2, 32'h0001_0000, 0, 32'h110);
        cpu_wr(4'd0, 32'd1, st);
        cyc = 0;
        while (n_reads < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
        vectors++;
        if (n_reads < 2) begin errs++; $display("FAIL rstmid_reach got reads=%0d want 2", n_reads); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (master_read !== 1'b0) begin errs++; $display("FAIL rstmid_read got %b want 0", master_read); end
        cpu_rd(4'd7, d, st); vectors++;
        if (d !== 32'd0) begin errs++; $display("FAIL rstmid_status got %h want 0", d); end
        cpu_rd(4'd0, d, st); vectors++;
        if (d !== 32'd0) begin errs++; $display("FAIL rstmid_result got %h want 0", d); end
        @(negedge clk); inj_rdata = 32'h7FFF_0000; inj_rdv = 1'b1;
        @(negedge clk); inj_rdv = 1'b0;
        repeat (3) @(negedge clk);
        cpu_rd(4'd7, d, st); vectors++;
        if (d !== 32'd0 || master_read !== 1'b0) begin
            errs++; $display("FAIL rstmid_spurious got status=%h read=%b want 0/0", d, master_read);
        end
        bp = 0;
        exp_v = ref_dot(2, 32'h0001_0000, 0);
        run_job(2, 32'h0001_0000, 0, 32'h110, rm, rr, ok);
        vectors++;
        if (!ok || rm !== exp_v || rr !== exp_v) begin
            errs++; $display("FAIL rstmid_fresh got mem=%h reg=%h want %h", rm, rr, exp_v);
        end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_basic;
        test_relu;
        test_len0;
        test_backpressure;
        test_slave_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
